// File: rtl/led_chaser_module_pkg.sv
// Shared encodings for the LED chaser: pattern modes, FSM states and divider sizing.
package led_chaser_module_pkg;

    localparam logic [1:0] MODE_ROT_L = 2'b00;
    localparam logic [1:0] MODE_ROT_R = 2'b01;
    localparam logic [1:0] MODE_PING  = 2'b10;
    localparam logic [1:0] MODE_CNT   = 2'b11;

    localparam int DIV_BITS = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Terminal divider count for a given number of edges per step.
    function automatic logic [DIV_BITS-1:0] div_last(input int step_div);
        return DIV_BITS'(step_div - 1);
    endfunction

endpackage

// File: rtl/led_chaser_module_pulse_edge_divider.sv
// Rising-edge detector on the incoming pulse level followed by a STEP_DIV edge divider.
module pulse_edge_divider
    import led_chaser_module_pkg::*;
#(
    parameter int STEP_DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pulse,
    input  logic i_run,
    output logic o_step_tick
);

    localparam logic [DIV_BITS-1:0] DIV_LAST = div_last(STEP_DIV);

    logic                r_pulse_d;
    logic [DIV_BITS-1:0] r_div;
    logic                w_edge;
    logic                w_wrap;

    assign w_edge      = i_pulse & ~r_pulse_d;
    assign w_wrap      = (r_div == DIV_LAST);
    assign o_step_tick = i_run & w_edge & w_wrap;

    // Pulse delay register and edge divider; the divider is held at zero outside RUN.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pulse_d <= 1'b0;
            r_div     <= {DIV_BITS{1'b0}};
        end else begin
            r_pulse_d <= i_pulse;
            if (!i_run) begin
                r_div <= {DIV_BITS{1'b0}};
            end else if (w_edge) begin
                r_div <= w_wrap ? {DIV_BITS{1'b0}} : r_div + {{(DIV_BITS-1){1'b0}}, 1'b1};
            end else begin
                r_div <= r_div;
            end
        end
    end

endmodule

// File: rtl/led_chaser_module.sv
// LED chaser: divides pulse-generator edges into pattern steps and drives the LED bank
// with rotate, ping-pong or binary-count patterns plus step/cycle strobes.
module led_chaser_module
    import led_chaser_module_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int STEP_DIV = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Pulse_In,
    input  logic             Enable_In,
    input  logic [1:0]       Mode_In,
    output logic [WIDTH-1:0] LED_Out,
    output logic             Step_Done,
    output logic             Cycle_Done
);

    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           r_state;
    logic [WIDTH-1:0] r_led;
    logic             r_dir_right;
    logic             r_step;
    logic             r_cycle;

    logic             w_step_tick;
    logic             w_run;
    logic             w_is_onehot;
    logic [WIDTH-1:0] w_next_led;
    logic             w_next_dir;
    logic             w_next_cycle;

    function automatic logic [WIDTH-1:0] init_pattern(input logic [1:0] mode);
        case (mode)
            MODE_ROT_L: return ONE;
            MODE_ROT_R: return MSB_ONLY;
            MODE_PING:  return ONE;
            MODE_CNT:   return ZERO;
            default:    return ZERO;
        endcase
    endfunction

    assign w_run       = (r_state == ST_RUN);
    assign w_is_onehot = (r_led != ZERO) && ((r_led & (r_led - ONE)) == ZERO);

    pulse_edge_divider #(
        .STEP_DIV (STEP_DIV)
    ) u_div (
        .i_clk       (CLK),
        .i_rst       (RST),
        .i_pulse     (Pulse_In),
        .i_run       (w_run),
        .o_step_tick (w_step_tick)
    );

    // Next pattern for a step; shift modes reload their seed if the bank is not one-hot.
    always_comb begin
        w_next_led   = r_led;
        w_next_dir   = r_dir_right;
        w_next_cycle = 1'b0;
        case (Mode_In)
            MODE_ROT_L: begin
                if (!w_is_onehot) begin
                    w_next_led = ONE;
                end else begin
                    w_next_led   = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
                    w_next_cycle = (w_next_led == ONE);
                end
            end
            MODE_ROT_R: begin
                if (!w_is_onehot) begin
                    w_next_led = MSB_ONLY;
                end else begin
                    w_next_led   = {r_led[0], r_led[WIDTH-1:1]};
                    w_next_cycle = (w_next_led == MSB_ONLY);
                end
            end
            MODE_PING: begin
                if (!w_is_onehot) begin
                    w_next_led = ONE;
                end else if (!r_dir_right) begin
                    if (r_led[WIDTH-1]) begin
                        w_next_dir   = 1'b1;
                        w_next_led   = {1'b0, r_led[WIDTH-1:1]};
                        w_next_cycle = (w_next_led == ONE);
                    end else begin
                        w_next_led = {r_led[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    if (r_led[0]) begin
                        w_next_dir = 1'b0;
                        w_next_led = {r_led[WIDTH-2:0], 1'b0};
                    end else begin
                        w_next_led   = {1'b0, r_led[WIDTH-1:1]};
                        w_next_cycle = (w_next_led == ONE);
                    end
                end
            end
            MODE_CNT: begin
                w_next_led   = r_led + ONE;
                w_next_cycle = (w_next_led == ZERO);
            end
            default: begin
                w_next_led = r_led;
            end
        endcase
    end

    // Run/idle FSM with registered pattern and strobes; disable wins over a step.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_led       <= ZERO;
            r_dir_right <= 1'b0;
            r_step      <= 1'b0;
            r_cycle     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_step      <= 1'b0;
                    r_cycle     <= 1'b0;
                    r_dir_right <= 1'b0;
                    if (Enable_In) begin
                        r_state <= ST_RUN;
                        r_led   <= init_pattern(Mode_In);
                    end else begin
                        r_led <= ZERO;
                    end
                end
                ST_RUN: begin
                    if (!Enable_In) begin
                        r_state <= ST_IDLE;
                        r_led   <= ZERO;
                        r_step  <= 1'b0;
                        r_cycle <= 1'b0;
                    end else if (w_step_tick) begin
                        r_led       <= w_next_led;
                        r_dir_right <= w_next_dir;
                        r_step      <= 1'b1;
                        r_cycle     <= w_next_cycle;
                    end else begin
                        r_step  <= 1'b0;
                        r_cycle <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_led   <= ZERO;
                    r_step  <= 1'b0;
                    r_cycle <= 1'b0;
                end
            endcase
        end
    end

    assign LED_Out    = r_led;
    assign Step_Done  = r_step;
    assign Cycle_Done = r_cycle;

endmodule

// File: tb/tb_led_chaser_module.sv
// Bench for led_chaser_module: two instances (STEP_DIV 1 and 3) share stimulus and are
// compared every cycle against an arithmetic reference model.
module tb_led_chaser_module;

    localparam int W = 4;
    localparam int N = 16;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         Pulse_In = 1'b0;
    logic         Enable_In = 1'b0;
    logic [1:0]   Mode_In = 2'b00;
    logic [W-1:0] led1, led3;
    logic         step1, step3, cyc1, cyc3;

    int n_checks = 0;
    int n_errors = 0;

    int m_led [2];
    int m_div [2];
    bit m_run [2];
    bit m_dir [2];
    bit m_pd  [2];
    bit m_step[2];
    bit m_cyc [2];

    always #5 CLK = ~CLK;

    led_chaser_module #(.WIDTH(W), .STEP_DIV(1)) u_dut1 (
        .CLK(CLK), .RST(RST), .Pulse_In(Pulse_In), .Enable_In(Enable_In),
        .Mode_In(Mode_In), .LED_Out(led1), .Step_Done(step1), .Cycle_Done(cyc1)
    );

    led_chaser_module #(.WIDTH(W), .STEP_DIV(3)) u_dut3 (
        .CLK(CLK), .RST(RST), .Pulse_In(Pulse_In), .Enable_In(Enable_In),
        .Mode_In(Mode_In), .LED_Out(led3), .Step_Done(step3), .Cycle_Done(cyc3)
    );

    function automatic int init_of(input int mode);
        if (mode == 1) return 8;
        if (mode == 3) return 0;
        return 1;
    endfunction

    function automatic int popcount(input int v);
        int c = 0;
        for (int i = 0; i < W; i++) if (((v >> i) % 2) == 1) c++;
        return c;
    endfunction

    function automatic int index_of(input int v);
        for (int i = 0; i < W; i++) if (v == (1 << i)) return i;
        return 0;
    endfunction

    task automatic apply_step(input int k);
        int mode = int'(Mode_In);
        int l = m_led[k];
        int p;
        m_cyc[k] = 1'b0;
        if (mode != 3 && popcount(l) != 1) begin
            l = init_of(mode);
        end else if (mode == 0) begin
            l = (l * 2) % N + l / (N / 2);
            m_cyc[k] = (l == 1);
        end else if (mode == 1) begin
            l = l / 2 + (l % 2) * (N / 2);
            m_cyc[k] = (l == N / 2);
        end else if (mode == 2) begin
            p = index_of(l);
            if (!m_dir[k]) begin
                if (p == W - 1) begin m_dir[k] = 1'b1; p = p - 1; end
                else p = p + 1;
            end else begin
                if (p == 0) begin m_dir[k] = 1'b0; p = 1; end
                else p = p - 1;
            end
            l = 1 << p;
            m_cyc[k] = m_dir[k] && (l == 1);
        end else begin
            l = (l + 1) % N;
            m_cyc[k] = (l == 0);
        end
        m_led[k] = l;
        m_step[k] = 1'b1;
    endtask

    task automatic model_edge(input int k);
        int d = (k == 0) ? 1 : 3;
        bit e;
        bit tick;
        if (RST) begin
            m_run[k] = 0; m_led[k] = 0; m_dir[k] = 0; m_div[k] = 0;
            m_pd[k] = 0; m_step[k] = 0; m_cyc[k] = 0;
            return;
        end
        e = Pulse_In && !m_pd[k];
        m_pd[k] = Pulse_In;
        m_step[k] = 0;
        m_cyc[k] = 0;
        if (!m_run[k]) begin
            m_div[k] = 0;
            m_dir[k] = 0;
            m_led[k] = Enable_In ? init_of(int'(Mode_In)) : 0;
            m_run[k] = Enable_In;
        end else begin
            tick = 0;
            if (e) begin
                m_div[k] = m_div[k] + 1;
                if (m_div[k] == d) begin m_div[k] = 0; tick = 1; end
            end
            if (!Enable_In) begin
                m_run[k] = 0;
                m_led[k] = 0;
            end else if (tick) begin
                apply_step(k);
            end
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        model_edge(0);
        model_edge(1);
        @(posedge CLK);
        #1;
        check("led_div1",  int'(led1),  m_led[0]);
        check("step_div1", int'(step1), int'(m_step[0]));
        check("cyc_div1",  int'(cyc1),  int'(m_cyc[0]));
        check("led_div3",  int'(led3),  m_led[1]);
        check("step_div3", int'(step3), int'(m_step[1]));
        check("cyc_div3",  int'(cyc3),  int'(m_cyc[1]));
    endtask

    task automatic edge_step();
        Pulse_In = 1'b1; cyc();
        Pulse_In = 1'b0; cyc();
    endtask

    task automatic restart(input logic [1:0] mode);
        Enable_In = 1'b0; cyc();
        Mode_In = mode; Enable_In = 1'b1; cyc();
    endtask

    initial begin
        // Reset held with enable on and pulse toggling: bank stays dark.
        RST = 1'b1; Enable_In = 1'b1; Mode_In = 2'b00;
        for (int i = 0; i < 4; i++) begin
            Pulse_In = ~Pulse_In;
            cyc();
        end
        check("reset_led", int'(led1), 0);
        Pulse_In = 1'b0;
        RST = 1'b0;
        cyc();
        check("load_rotl", int'(led1), 1);

        // Rotate left, four steps back to the seed.
        for (int i = 0; i < 4; i++) begin
            Pulse_In = 1'b1; cyc();
            if (i == 3) begin
                check("rotl_wrap_led", int'(led1), 1);
                check("rotl_wrap_cyc", int'(cyc1), 1);
            end
            Pulse_In = 1'b0; cyc();
        end

        // Rotate right with a long-held pulse counted once, then five more edges.
        restart(2'b01);
        check("load_rotr", int'(led3), 8);
        Pulse_In = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        Pulse_In = 1'b0; cyc();
        for (int i = 0; i < 5; i++) edge_step();
        check("div3_led", int'(led3), 2);

        // Ping-pong out and back.
        restart(2'b10);
        for (int i = 0; i < 6; i++) edge_step();
        check("ping_led", int'(led1), 1);

        // Counter full wrap, then to 0101 and switch to rotate left.
        restart(2'b11);
        for (int i = 0; i < 16; i++) edge_step();
        check("cnt_wrap_led", int'(led1), 0);
        for (int i = 0; i < 5; i++) edge_step();
        check("cnt_led_5", int'(led1), 5);
        Mode_In = 2'b00;
        Pulse_In = 1'b1; cyc();
        check("reload_led",  int'(led1),  1);
        check("reload_step", int'(step1), 1);
        check("reload_cyc",  int'(cyc1),  0);
        Pulse_In = 1'b0; cyc();

        // Disable coinciding with a step edge.
        Pulse_In = 1'b1; Enable_In = 1'b0; cyc();
        check("prio_led",  int'(led1),  0);
        check("prio_step", int'(step1), 0);
        Pulse_In = 1'b0; Enable_In = 1'b1; cyc();
        check("reenable_led", int'(led1), 1);

        // Randomised run including mode changes, disables and mid-run resets.
        for (int i = 0; i < 600; i++) begin
            Pulse_In = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) Enable_In = ~Enable_In;
            else if (!Enable_In && $urandom_range(0, 3) == 0) Enable_In = 1'b1;
            if ($urandom_range(0, 19) == 0) Mode_In = 2'($urandom_range(0, 3));
            RST = ($urandom_range(0, 149) == 0);
            cyc();
        end
        RST = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
